// File: rtl/page_ctrl_pkg.sv
// page_ctrl_pkg: key codes, frame boundary default, FSM state encoding and a
// lowest-set-bit helper shared by the page controller and its key debouncer.
package page_ctrl_pkg;

  localparam int unsigned KeyW  = 4;
  localparam int unsigned PageW = 4;

  // Key map of the matrix scanner
  localparam logic [KeyW-1:0] KEY_NEXT    = 4'd0;
  localparam logic [KeyW-1:0] KEY_PREV    = 4'd1;
  localparam logic [KeyW-1:0] KEY_DIRECT0 = 4'd4;
  localparam logic [KeyW-1:0] KEY_HOME    = 4'd15;

  // First non-visible line of a 640x480 frame
  localparam int unsigned V_ACTIVE_DEFAULT = 480;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPend   = 2'd1,
    StSwap   = 2'd2,
    StSettle = 2'd3
  } page_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [KeyW-1:0] lowest_set(input logic [15:0] vec);
    logic [KeyW-1:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/page_ctrl_if.sv
// page_ctrl_if: key/video inputs and page outputs of page_ctrl.
//   master: drives btns, x_pos, y_pos; observes page/key outputs (scanner/timing side)
//   slave : the page controller
interface page_ctrl_if;
  import page_ctrl_pkg::*;

  logic [15:0]      btns;
  logic [9:0]       x_pos;
  logic [9:0]       y_pos;
  logic [PageW-1:0] page_sel;
  logic             page_switch;
  logic             blank;
  logic             key_evt;
  logic [KeyW-1:0]  key_code;

  modport master (
    output btns, x_pos, y_pos,
    input  page_sel, page_switch, blank, key_evt, key_code
  );

  modport slave (
    input  btns, x_pos, y_pos,
    output page_sel, page_switch, blank, key_evt, key_code
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a 16-bit raw key vector, samples it every
// DEBOUNCE_CYCLES cycles and reports the lowest key whose stable level rose.
//   clk_i, rst_ni : clock, async active-low reset
//   btns_i        : raw key levels, asynchronous
//   press_o       : one-cycle pulse per accepted press
//   idx_o         : index of the last accepted key, held between presses
module key_debounce import page_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [15:0]     btns_i,
  output logic            press_o,
  output logic [KeyW-1:0] idx_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]     sync1_q, sync2_q;
  logic [15:0]     samp_q, samp_d;
  logic [15:0]     stable_q, stable_d;
  logic [15:0]     rise;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sample;
  logic            press_q, press_d;
  logic [KeyW-1:0] idx_q, idx_d;

  always_comb begin
    sample   = (cnt_q == CntMax);
    cnt_d    = sample ? '0 : cnt_q + 1'b1;
    samp_d   = samp_q;
    stable_d = stable_q;
    rise     = '0;
    press_d  = 1'b0;
    idx_d    = idx_q;
    if (sample) begin
      samp_d   = sync2_q;
      // A bit takes its new level only if two consecutive samples agree.
      stable_d = (~(sync2_q ^ samp_q) & sync2_q) | ((sync2_q ^ samp_q) & stable_q);
      rise     = stable_d & ~stable_q;
      if (|rise) begin
        press_d = 1'b1;
        idx_d   = lowest_set(rise);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      sync1_q  <= btns_i;
      sync2_q  <= sync1_q;
      samp_q   <= samp_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      idx_q    <= idx_d;
    end
  end

  assign press_o = press_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/page_ctrl.sv
// page_ctrl: maps debounced key presses to display-page requests and swaps the
// active page only at the frame boundary, blanking the picture for one frame.
//   vga_clk, vga_rst_n : pixel clock, async active-low reset
//   pg_io (slave)      : btns/x_pos/y_pos in; page_sel, page_switch, blank,
//                        key_evt, key_code out
module page_ctrl import page_ctrl_pkg::*; #(
  parameter int unsigned NUM_PAGES       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEFAULT
) (
  input  logic       vga_clk,
  input  logic       vga_rst_n,
  page_ctrl_if.slave pg_io
);

  localparam logic [PageW-1:0] LastPage   = PageW'(NUM_PAGES - 1);
  localparam int unsigned      DirectLast = 32'(KEY_DIRECT0) + NUM_PAGES - 1;

  logic             key_evt;
  logic [KeyW-1:0]  key_code;

  logic             at_bound, at_bound_q, frame_tick;
  logic             req_valid;
  logic [PageW-1:0] req_page;

  page_state_e      state_q, state_d;
  logic [PageW-1:0] target_q, target_d;
  logic [PageW-1:0] page_sel_q, page_sel_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk_i  (vga_clk),
    .rst_ni (vga_rst_n),
    .btns_i (pg_io.btns),
    .press_o(key_evt),
    .idx_o  (key_code)
  );

  // Strobe only on entry to the boundary pixel, even if it is held.
  assign at_bound   = (pg_io.y_pos == 10'(V_ACTIVE)) && (pg_io.x_pos == '0);
  assign frame_tick = at_bound & ~at_bound_q;

  // target_q always equals page_sel_q while nothing is pending, so it is the
  // correct base for next/previous in every state.
  always_comb begin
    req_valid = 1'b0;
    req_page  = target_q;
    if (key_evt) begin
      if (key_code == KEY_HOME) begin
        req_valid = 1'b1;
        req_page  = '0;
      end else if (key_code == KEY_NEXT) begin
        req_valid = 1'b1;
        req_page  = (target_q == LastPage) ? '0 : target_q + 1'b1;
      end else if (key_code == KEY_PREV) begin
        req_valid = 1'b1;
        req_page  = (target_q == '0) ? LastPage : target_q - 1'b1;
      end else if ((32'(key_code) >= 32'(KEY_DIRECT0)) && (32'(key_code) <= DirectLast)) begin
        req_valid = 1'b1;
        req_page  = key_code - KEY_DIRECT0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    page_sel_d = page_sel_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && (req_page != page_sel_q)) begin
          target_d = req_page;
          state_d  = StPend;
        end
      end
      StPend: begin
        if (req_valid) target_d = req_page;
        // page_sel is loaded on entry so it shows the new page during SWAP.
        if (frame_tick) begin
          page_sel_d = target_d;
          state_d    = StSwap;
        end
      end
      StSwap: begin
        if (req_valid) target_d = req_page;
        state_d = StSettle;
      end
      StSettle: begin
        if (req_valid) target_d = req_page;
        if (frame_tick) state_d = (target_d != page_sel_q) ? StPend : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      page_sel_q <= '0;
      at_bound_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      page_sel_q <= page_sel_d;
      at_bound_q <= at_bound;
    end
  end

  assign pg_io.page_sel    = page_sel_q;
  assign pg_io.page_switch = (state_q == StSwap);
  assign pg_io.blank       = (state_q == StSwap) || (state_q == StSettle);
  assign pg_io.key_evt     = key_evt;
  assign pg_io.key_code    = key_code;

endmodule

// File: doc/page_ctrl.md
PAGE_CTRL -- requirements
Module: page_ctrl

Interface
REQ-001 Parameter NUM_PAGES, default 4, number of selectable display pages (2..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, vga_clk cycles between key-vector samples (about 10 ms at 25 MHz).
REQ-003 Parameter V_ACTIVE, default 480, first non-visible line, marking the frame boundary.
REQ-004 vga_clk  input  1  single clock for the whole block (VGA pixel clock).
REQ-005 vga_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 btns  input  16  raw key levels from the matrix scanner; bit i = key i; asynchronous to vga_clk.
REQ-007 x_pos  input  10  current VGA column.
REQ-008 y_pos  input  10  current VGA row.
REQ-009 page_sel  output  4  active page index driven to the page mux.
REQ-010 page_switch  output  1  one-cycle pulse in the cycle page_sel changes.
REQ-011 blank  output  1  forces black pixels while the new page settles.
REQ-012 key_evt  output  1  one-cycle pulse per accepted debounced key press.
REQ-013 key_code  output  4  index of the last accepted key; holds between events.

Function
REQ-014 btns SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 A shared counter SHALL sample the synchronized vector every DEBOUNCE_CYCLES cycles; a bit is stable once it matches in two consecutive samples.
REQ-016 A press SHALL be the 0->1 transition of a stable bit; when several bits rise in the same sample, only the lowest index is accepted and the rest are dropped.
REQ-017 Each accepted press SHALL pulse key_evt for one cycle and load key_code, independent of FSM state.
REQ-018 Key map: key 0 = next, key 1 = previous, keys 4..(4+NUM_PAGES-1) = direct page (key-4), key 15 = page 0; all other keys produce key_evt only.
REQ-019 Next/previous SHALL be computed from the pending target if one exists, otherwise from page_sel; next from NUM_PAGES-1 wraps to 0 and previous from 0 wraps to NUM_PAGES-1.
REQ-020 frame_tick SHALL be a one-cycle strobe on the first cycle with y_pos==V_ACTIVE and x_pos==0.
REQ-021 The FSM SHALL have states IDLE, PEND, SWAP and SETTLE.
REQ-022 IDLE: a mapped request whose target differs from page_sel loads target and moves to PEND; a target equal to page_sel is ignored.
REQ-023 PEND: a new request overwrites target; on frame_tick, move to SWAP.
REQ-024 SWAP (one cycle): page_sel <= target, page_switch=1, blank=1, then move to SETTLE.
REQ-025 SETTLE: blank stays 1 until the next frame_tick, then go to PEND if a request was captured during SWAP/SETTLE and its target differs from page_sel, else go to IDLE; blank=0 from that cycle.
REQ-026 A request arriving in the same cycle as frame_tick in PEND SHALL update target before the SWAP transition is taken.
REQ-027 page_sel SHALL change only in SWAP; the latency from press acceptance to page_sel change is at most one frame plus one cycle.

Reset
REQ-028 On vga_rst_n low: page_sel=0, page_switch=0, blank=0, key_evt=0, key_code=0, state=IDLE, target=0, synchronizer/debounce state=0, counter=0.
REQ-029 Reset mid-PEND or mid-SETTLE SHALL discard the pending target and deassert blank immediately.

Structure
REQ-030 A shared header page_defs.vh SHALL hold the key codes (KEY_NEXT, KEY_PREV, KEY_DIRECT0, KEY_HOME), V_ACTIVE and the FSM state encodings.
REQ-031 Synchronizer, debounce and press detection SHALL live in sub-module key_debounce, which outputs a press pulse and a 4-bit index; page_ctrl contains the mapping and the FSM.

Verification (DEBOUNCE_CYCLES=4, NUM_PAGES=4)
REQ-032 Reset, then hold btns[0]=1 for 20 cycles -> one key_evt with key_code=0; page_sel 0->1 exactly at the next frame_tick+1, with a page_switch pulse and blank high for one frame.
REQ-033 With page_sel=0, press key 1 -> page_sel=3 (wrap); then press key 0 twice before the frame boundary -> single switch from 3 to 1.
REQ-034 Press keys 5 and 6 in the same sample -> only key_code=5 is accepted; page_sel=1.
REQ-035 With page_sel=2, press key 6 -> key_evt pulses, FSM stays IDLE, no page_switch.
REQ-036 A 2-cycle glitch on btns[4] -> no key_evt; press key 7 in PEND, then assert vga_rst_n low -> page_sel=0, blank=0, and no switch after release.
